adc_spi_reader: RTL

- Upstream feeder of speckle_sensor_controller: drives an external 12-bit serial ADC (16-bit frame, 4 leading zeros then 12 data bits MSB first) over a 3-wire SPI link.
- On each conversion request (controller's o_adc_trigger) it runs one CS/SCLK frame, deserialises the sample, and presents it on o_adc_val with the o_adc_done ready/valid level the controller consumes as i_adc_val / i_adc_done.

---
 rtl/adc_spi_reader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/adc_spi_reader.sv
// Drives a 3-wire serial ADC: one CS/SCLK frame per trigger, then presents the
// 12-bit sample with a done level and a one-cycle valid pulse.
module adc_spi_reader #(
  parameter int NB_DATA      = 12,
  parameter int NB_FRAME     = 16,
  parameter int NB_DIV       = 8,
  parameter int QUIET_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_trigger,
  input  logic [NB_DIV-1:0]  i_clk_div,
  input  logic               i_sdata,
  output logic               o_cs_n,
  output logic               o_sclk,
  output logic [NB_DATA-1:0] o_adc_val,
  output logic               o_adc_done,
  output logic               o_adc_valid,
  output logic               o_frame_err,
  output logic [1:0]         dbg_state
);

  // Handshake: o_adc_done high means idle with o_adc_val valid; a one-cycle
  // i_trigger is accepted only while idle, never queued. o_adc_valid pulses
  // for exactly one cycle on the edge o_adc_val takes a new sample.

  localparam int NB_BIT = $clog2(NB_FRAME) + 1;
  localparam int NB_Q   = $clog2(QUIET_CYCLES + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [NB_DIV-1:0]   div_lat;
  logic [NB_DIV-1:0]   div_cnt;
  logic [NB_BIT-1:0]   bit_cnt;
  logic [NB_Q-1:0]     quiet_cnt;
  logic [NB_FRAME-1:0] shift_reg;
  logic                phase_end;
  logic                last_bit;
  logic                quiet_end;

  assign dbg_state = state;

  always_comb begin
    phase_end  = (div_cnt == div_lat - NB_DIV'(1));
    last_bit   = (bit_cnt == NB_BIT'(NB_FRAME));
    quiet_end  = (quiet_cnt == NB_Q'(QUIET_CYCLES - 1));
    state_next = state;
    case (state)
      IDLE:    if (i_trigger) state_next = SETUP;
      SETUP:   if (phase_end) state_next = SHIFT;
      SHIFT: begin
        if (phase_end && o_sclk && last_bit)
          state_next = (QUIET_CYCLES == 0) ? IDLE : QUIET;
      end
      QUIET:   if (quiet_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_cs_n      <= 1'b1;
      o_sclk      <= 1'b1;
      o_adc_val   <= '0;
      o_adc_done  <= 1'b1;
      o_adc_valid <= 1'b0;
      o_frame_err <= 1'b0;
      div_lat     <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      quiet_cnt   <= '0;
      shift_reg   <= '0;
    end else begin
      o_adc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_trigger) begin
            div_lat     <= (i_clk_div == '0) ? NB_DIV'(1) : i_clk_div;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            quiet_cnt   <= '0;
            shift_reg   <= '0;
            o_cs_n      <= 1'b0;
            o_adc_done  <= 1'b0;
            o_frame_err <= 1'b0;
          end
        end
        SETUP: begin
          if (phase_end) begin
            div_cnt <= '0;
            o_sclk  <= 1'b0;
          end else begin
            div_cnt <= div_cnt + NB_DIV'(1);
          end
        end
        SHIFT: begin
          if (!phase_end) begin
            div_cnt <= div_cnt + NB_DIV'(1);
          end else begin
            div_cnt <= '0;
            if (!o_sclk) begin
              // Sample on the edge that raises SCLK.
              o_sclk    <= 1'b1;
              shift_reg <= {shift_reg[NB_FRAME-2:0], i_sdata};
              bit_cnt   <= bit_cnt + NB_BIT'(1);
            end else if (last_bit) begin
              o_cs_n      <= 1'b1;
              o_adc_val   <= shift_reg[NB_DATA-1:0];
              o_adc_valid <= 1'b1;
              o_frame_err <= |shift_reg[NB_FRAME-1:NB_DATA];
              if (QUIET_CYCLES == 0) o_adc_done <= 1'b1;
            end else begin
              o_sclk <= 1'b0;
            end
          end
        end
        QUIET: begin
          if (quiet_end) o_adc_done <= 1'b1;
          else           quiet_cnt  <= quiet_cnt + NB_Q'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
